// File: rtl/rv32m_arbiter.sv
// Round-robin arbiter sharing one RV32M mul/div unit between two requesters.
// Optional WAIT-state timeout: define RV32M_ARB_TIMEOUT_EN.
module rv32m_arbiter #(
  parameter int MIN_LAT        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [2:0]  req0_funct3,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [2:0]  req1_funct3,
  output logic        unit_in_valid,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  output logic [2:0]  unit_funct3,
  input  logic [31:0] unit_rd,
  input  logic        unit_out_valid,
  input  logic        unit_in_error,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_rd,
  output logic        resp_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [7:0] THR    = 8'(MIN_LAT - 1);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic gnt0, gnt1, hit, tmo;

  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid || prio_q);
  // Ignore the unit's valid until the stale one from the last op has cleared
  assign hit  = unit_out_valid && (cnt_q >= THR);

`ifdef RV32M_ARB_TIMEOUT_EN
  assign tmo = (cnt_q >= TO_LIM);
`else
  logic unused_to;
  assign unused_to = ^TO_LIM;
  assign tmo       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt0: begin
            rs1_d   = req0_rs1;
            rs2_d   = req0_rs2;
            f3_d    = req0_funct3;
            id_d    = 1'b0;
            state_d = ISSUE;
          end
          gnt1: begin
            rs1_d   = req1_rs1;
            rs2_d   = req1_rs2;
            f3_d    = req1_funct3;
            id_d    = 1'b1;
            state_d = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (hit) begin
          rd_d    = unit_rd;
          err_d   = unit_in_error;
          state_d = RESP;
        end else if (tmo) begin
          rd_d    = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
      f3_q    <= 3'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready    = (state_q == IDLE) && gnt0;
  assign req1_ready    = (state_q == IDLE) && gnt1;
  assign unit_in_valid = (state_q == ISSUE);
  assign resp_valid    = (state_q == RESP);
  assign unit_rs1      = rs1_q;
  assign unit_rs2      = rs2_q;
  assign unit_funct3   = f3_q;
  assign resp_id       = id_q;
  assign resp_rd       = rd_q;
  assign resp_error    = err_q;

endmodule

// File: tb/tb_rv32m_arbiter.sv
// Scoreboard bench for rv32m_arbiter with a behavioural M-unit model.
// Define RV32M_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_rv32m_arbiter;

  logic        clk = 0;
  logic        rst = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
  logic [2:0]  req0_funct3 = 0, req1_funct3 = 0;
  logic        unit_in_valid;
  logic [31:0] unit_rs1, unit_rs2;
  logic [2:0]  unit_funct3;
  logic [31:0] unit_rd = 0;
  logic        unit_out_valid = 0, unit_in_error = 0;
  logic        resp_valid, resp_ready = 0, resp_id, resp_error;
  logic [31:0] resp_rd;

  rv32m_arbiter #(.MIN_LAT(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_funct3(req0_funct3),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_funct3(req1_funct3),
    .unit_in_valid(unit_in_valid), .unit_rs1(unit_rs1),
    .unit_rs2(unit_rs2), .unit_funct3(unit_funct3),
    .unit_rd(unit_rd), .unit_out_valid(unit_out_valid),
    .unit_in_error(unit_in_error),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_rd(resp_rd), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   glog[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, npulse = 0, r1seen = 0;
  int   issue_cyc = 0, rv_cyc = 0, acc_cyc = 0;
  logic rv_prev = 0, busy = 0, stab_bad = 0;
  logic [34:0] ref_ops = 0;

  // M-unit model knobs
  int          k = -1, mlat = 3;
  logic        mstale = 0, mnever = 0, manual = 0;
  logic [31:0] stale_rd = 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // M-unit model: answers mlat cycles after the start pulse
  always @(negedge clk) begin
    if (!rst) k = -1;
    if (!manual) begin
      if (unit_in_valid) k = 0;
      else if (k >= 0 && k < 100000) k++;
      unit_out_valid = 0;
      unit_rd = 0;
      unit_in_error = 0;
      if (mstale && k >= 0 && k < 2) begin
        unit_out_valid = 1;
        unit_rd = stale_rd;
      end else if (k == mlat && !mnever) begin
        unit_out_valid = 1;
        if (unit_funct3 == 3'b101) begin
          unit_in_error = (unit_rs2 == 0);
          unit_rd = (unit_rs2 == 0) ? 32'hFFFF_FFFF : unit_rs1 / unit_rs2;
        end else begin
          unit_rd = unit_rs1 * unit_rs2;
        end
      end
    end
  end

  // Monitor: grants, operand hold, and scoreboard on response handshake
  always @(negedge clk) begin
    if (!rst) begin
      busy = 0;
      stab_bad = 0;
      rv_prev = 0;
    end else begin
      if (req0_valid && req0_ready) begin glog.push_back(0); acc_cyc = cyc; end
      if (req1_valid && req1_ready) begin glog.push_back(1); acc_cyc = cyc; end
      if (req1_ready) r1seen++;
      if (unit_in_valid) begin
        npulse++;
        issue_cyc = cyc;
        busy = 1;
        ref_ops = {unit_funct3, unit_rs1};
      end else if (busy && ({unit_funct3, unit_rs1} !== ref_ops)) begin
        stab_bad = 1;
      end
      if (resp_valid && !rv_prev) rv_cyc = cyc;
      rv_prev = resp_valid;
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
          chk("resp_rd", resp_rd, e.rd);
          chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          chk("operand_hold", {31'd0, stab_bad}, 32'd0);
        end
        busy = 0;
        stab_bad = 0;
      end
    end
  end

  task automatic issue(input bit id, input logic [31:0] a, b,
                       input logic [2:0] f);
    bit ok = 0;
    if (id) begin
      req1_rs1 = a; req1_rs2 = b; req1_funct3 = f; req1_valid = 1;
    end else begin
      req0_rs1 = a; req0_rs2 = b; req0_funct3 = f; req0_valid = 1;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    if (id) req1_valid = 0; else req0_valid = 0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", q.size(), 0);
    q.delete();
    @(posedge clk); #2;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rs1"}, unit_rs1, 0);
    chk({nm, "_rs2"}, unit_rs2, 0);
    chk({nm, "_rd"}, resp_rd, 0);
    chk({nm, "_ctl"},
        {25'd0, unit_funct3, unit_in_valid, resp_valid, resp_id, resp_error},
        0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 0;
    #1;
    @(posedge clk); #2;
    rst = 1;
  endtask

  initial begin
    int bad;
    int p0;
    // reset state
    @(negedge clk);
    chk_zero("reset");
    chk("reset_ready", {30'd0, req0_ready, req1_ready}, 0);
    @(posedge clk); #2;
    rst = 1;
    resp_ready = 1;

    // single MUL from req0
    mlat = 3; npulse = 0; r1seen = 0;
    q.push_back('{1'b0, 32'd42, 1'b0});
    issue(0, 32'd7, 32'd6, 3'b000);
    drain(30);
    chk("single_pulses", npulse, 1);
    chk("single_r1_ready", r1seen, 0);

    // contention, round robin from prio=0
    do_reset();
    mlat = 2;
    glog.delete();
    for (int i = 0; i < 2; i++) begin
      q.push_back('{1'b0, 32'd15, 1'b0});
      q.push_back('{1'b1, 32'd16, 1'b0});
    end
    req0_rs1 = 3; req0_rs2 = 5; req0_funct3 = 0;
    req1_rs1 = 4; req1_rs2 = 4; req1_funct3 = 0;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (glog.size() >= 4) break;
    end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    drain(30);
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("rr_grant%0d", i), glog[i], i % 2);
    chk("turnaround", rv_cyc - acc_cyc, 4);

    // stale unit valid from the previous op must be masked
    mstale = 1; mlat = 3;
    q.push_back('{1'b0, 32'h1234, 1'b0});
    issue(0, 32'h1234, 32'd1, 3'b000);
    drain(30);
    mstale = 0;

    // divide by zero, response held under backpressure
    resp_ready = 0;
    q.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
    issue(1, 32'd100, 32'd0, 3'b101);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    @(posedge clk); #2;
    req0_rs1 = 9; req0_rs2 = 9; req0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 1);
      chk("hold_id", {31'd0, resp_id}, 1);
      chk("hold_rd", resp_rd, 32'hFFFF_FFFF);
      chk("hold_err", {31'd0, resp_error}, 1);
      chk("hold_ready", {30'd0, req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #2;
    req0_valid = 0;
    resp_ready = 1;
    drain(30);
    p0 = npulse;
    repeat (4) @(posedge clk);
    #2;
    chk("dropped_valid", npulse, p0);

    // reset during WAIT, late unit valid ignored
    mlat = 50;
    issue(0, 32'd2, 32'd2, 3'b000);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk_zero("midreset");
    @(posedge clk); #2;
    manual = 1;
    unit_out_valid = 1; unit_rd = 32'h0BAD; unit_in_error = 1;
    rst = 1;
    p0 = npulse; bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) bad++;
      if (i == 1) begin unit_out_valid = 0; unit_in_error = 0; end
    end
    chk("post_reset_resp", bad, 0);
    chk("post_reset_pulse", npulse, p0);
    manual = 0; mlat = 3;
    @(posedge clk); #2;
    q.push_back('{1'b0, 32'd25, 1'b0});
    issue(0, 32'd5, 32'd5, 3'b000);
    drain(30);

`ifdef RV32M_ARB_TIMEOUT_EN
    mnever = 1;
    q.push_back('{1'b0, 32'hFFFF_FFFF, 1'b1});
    issue(0, 32'd1, 32'd1, 3'b000);
    drain(60);
    chk("timeout_lat", rv_cyc - issue_cyc - 1, 16);
    mnever = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32m_arbiter.md
Name: rv32m_arbiter

Overview:
- Shares one RV32M multiply/divide unit between two requesters (req0, req1) using round-robin arbitration.
- Latches the winner's operands and funct3 and holds them stable for the whole operation, because the unit selects its result from funct3 every cycle.
- Issues a one-cycle start pulse, waits for the unit's completion, then returns result, error flag and requester ID over a valid/ready response channel.
- Sits between the issue logic and the M-unit instance.

Parameters:
- MIN_LAT, 2: cycles after the start pulse during which unit_out_valid is ignored, masking the stale valid left from the previous operation; legal range 1..15.
- TIMEOUT_CYCLES, 64: WAIT-state cycle limit. Used only when RV32M_ARB_TIMEOUT_EN is defined; legal range MIN_LAT+1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_rs1, req0_rs2  in  32 each  requester 0 operands
- req0_funct3  in  3  requester 0 operation select
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_funct3: same as requester 0, for requester 1
- unit_in_valid  out  1  one-cycle start pulse to the M-unit
- unit_rs1, unit_rs2  out  32 each  latched operands
- unit_funct3  out  3  latched funct3
- unit_rd  in  32  M-unit result
- unit_out_valid  in  1  M-unit result valid
- unit_in_error  in  1  M-unit error flag (divide by zero)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  requester that owns the response
- resp_rd  out  32  result
- resp_error  out  1  error flag

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, prio=0, wait counter=0.
  - All outputs 0: unit_rs1/unit_rs2/unit_funct3, resp_rd/resp_id/resp_error, unit_in_valid, resp_valid.
  - An in-flight operation is discarded; any late unit_out_valid after reset release is ignored because state is IDLE.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE:
  - Grant goes to the requester whose valid is high. If both are high, grant goes to the requester selected by prio.
  - reqN_ready is combinational: (state==IDLE) && granted N. The other ready stays 0; both are 0 outside IDLE.
  - On valid&&ready: latch rs1, rs2, funct3 into the unit_* registers, latch the ID, go to ISSUE.
- ISSUE:
  - unit_in_valid=1 for exactly this cycle.
  - Clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle, saturating at 255.
  - When counter >= MIN_LAT-1 and unit_out_valid=1: capture resp_rd=unit_rd and resp_error=unit_in_error, go to RESP.
  - unit_out_valid before that threshold is ignored.
- RESP:
  - resp_valid=1; resp_id, resp_rd and resp_error held stable.
  - On resp_ready=1: go to IDLE and set prio to the requester that was not just served.
  - While resp_ready stays 0, hold indefinitely; no new request is accepted.
- Throughput: at most one operation in flight.
- Minimum turnaround from accept to resp_valid is MIN_LAT+2 cycles. Accept cycle t → ISSUE at t+1 → first qualifying WAIT cycle at t+1+MIN_LAT → resp_valid high at t+2+MIN_LAT.
- unit_rs1, unit_rs2 and unit_funct3 change only on an IDLE acceptance edge; they never change during ISSUE, WAIT or RESP.
- resp_valid deasserts on the cycle after the handshake. With resp_ready held high, back-to-back operations need at least 1 IDLE cycle between them.
- A requester may drop valid without a handshake; nothing is latched in that case.

Optional Feature:
- RV32M_ARB_TIMEOUT_EN defined:
  - In WAIT, if the counter reaches TIMEOUT_CYCLES-1 without a qualifying unit_out_valid, go to RESP with resp_rd=32'hFFFF_FFFF and resp_error=1.
  - If unit_out_valid arrives in the same cycle as the timeout, the real result wins.
- Not defined:
  - No timeout logic; WAIT waits forever. TIMEOUT_CYCLES is unused.

Test Plan:
- Single request: req0 MUL, rs1=7, rs2=6, funct3=000; model unit answers 42 three cycles after the pulse → one unit_in_valid pulse, then resp_valid with resp_id=0, resp_rd=42, resp_error=0; req1_ready stays 0 throughout.
- Contention: req0 and req1 held valid continuously, resp_ready=1 → grants alternate 0,1,0,1 over 4 operations; no requester granted twice in a row.
- Stale valid: model holds unit_out_valid=1 from the previous op, returns the new value 0x1234 at MIN_LAT+1 → resp_rd=0x1234, never the stale value; unit_funct3 stable over the entire WAIT.
- Divide error: req1 DIVU, rs1=100, rs2=0; model raises unit_in_error with rd=0xFFFFFFFF → resp_error=1, resp_id=1; with resp_ready=0 for 5 cycles, resp_* stays stable and both readys stay 0.
- Reset mid-operation: assert rst low during WAIT, then release; model pulses unit_out_valid → all outputs 0, state IDLE, no resp_valid; next req0 accepted normally.
- Timeout (RV32M_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): model never responds → resp_valid rises 16 cycles after the first WAIT cycle, resp_rd=0xFFFFFFFF, resp_error=1.
